// File: rtl/uart_cmd_framer.sv
// Assembles UART bytes into short/long command frames and presents them on a valid/ready port.
// Optional inter-byte timeout is enabled by defining CMD_FRAMER_TIMEOUT_EN.
module uart_cmd_framer #(
    parameter int         LONG_LEN    = 18,
    parameter int         SHORT_LEN   = 3,
    parameter logic [7:0] CMD_SHORT   = 8'h41,
    parameter logic [7:0] CMD_LONG0   = 8'h40,
    parameter logic [7:0] CMD_LONG1   = 8'h42,
    parameter logic [7:0] CMD_LONG2   = 8'h43,
    parameter int         TIMEOUT_CYC = 1_033_400,
    parameter int         TO_W        = 21
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         cmd_valid,
    input  logic         cmd_ready,
    output logic [7:0]   cmd_code,
    output logic [7:0]   cmd_arg,
    output logic [127:0] cmd_payload,
    output logic         frame_err,
    output logic         overrun,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    if ((2 ** TO_W) <= TIMEOUT_CYC) begin : g_bad_to_w
        $error("TO_W too narrow for TIMEOUT_CYC");
    end

    state_t         state;
    logic [4:0]     idx;
    logic [4:0]     len;
    logic [7:0]     code;
    logic [7:0]     arg;
    logic [127:0]   shreg;
    logic           start;
    logic           last_byte;
    logic           collect_byte;
`ifdef CMD_FRAMER_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
`endif

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_SHORT) || (b == CMD_LONG0) || (b == CMD_LONG1) || (b == CMD_LONG2);
    endfunction

    function automatic logic [4:0] frame_len(input logic [7:0] b);
        return (b == CMD_SHORT) ? 5'(SHORT_LEN) : 5'(LONG_LEN);
    endfunction

    // A new command may start from IDLE or in the very cycle a held frame is accepted.
    assign start        = rx_valid && is_cmd(rx_data) &&
                          ((state == IDLE) || ((state == HOLD) && cmd_ready));
    assign last_byte    = (idx == (len - 5'd1));
    assign collect_byte = (state == COLLECT) && rx_valid && !last_byte;

    always_ff @(posedge clk) begin
        if (start) begin
            code <= rx_data;
        end
        if (collect_byte) begin
            shreg <= {shreg[119:0], rx_data};
            if (idx == 5'd1) begin
                arg <= rx_data;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            idx         <= 5'd0;
            len         <= 5'd0;
            cmd_valid   <= 1'b0;
            cmd_code    <= 8'd0;
            cmd_arg     <= 8'd0;
            cmd_payload <= 128'd0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
`ifdef CMD_FRAMER_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if ((state == HOLD) && cmd_ready) begin
                cmd_valid <= 1'b0;
            end
            if (start) begin
                state <= COLLECT;
                busy  <= 1'b1;
                len   <= frame_len(rx_data);
                idx   <= 5'd1;
`ifdef CMD_FRAMER_TIMEOUT_EN
                to_cnt <= '0;
`endif
            end else begin
                case (state)
                    COLLECT: begin
                        if (rx_valid) begin
`ifdef CMD_FRAMER_TIMEOUT_EN
                            to_cnt <= '0;
`endif
                            if (!last_byte) begin
                                idx <= idx + 5'd1;
                            end else if (rx_data == code) begin
                                state       <= HOLD;
                                cmd_valid   <= 1'b1;
                                cmd_code    <= code;
                                cmd_arg     <= arg;
                                cmd_payload <= (len == 5'(SHORT_LEN)) ? {arg, 120'd0} : shreg;
                            end else begin
                                // Mismatched terminator is dropped, never re-parsed as a command.
                                frame_err <= 1'b1;
                                state     <= IDLE;
                                busy      <= 1'b0;
                            end
                        end
`ifdef CMD_FRAMER_TIMEOUT_EN
                        else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
`endif
                    end
                    HOLD: begin
                        if (cmd_ready) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (rx_valid) begin
                            overrun <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Scoreboard bench for uart_cmd_framer: expected frames are queued by stimulus, popped on handshake.
module tb_uart_cmd_framer;

    typedef struct packed {
        logic [7:0]   code;
        logic [7:0]   arg;
        logic [127:0] pl;
    } frame_t;

    logic         clk = 1'b0;
    logic         nreset = 1'b0;
    logic [7:0]   rx_data = 8'd0;
    logic         rx_valid = 1'b0;
    logic         cmd_valid;
    logic         cmd_ready = 1'b0;
    logic [7:0]   cmd_code;
    logic [7:0]   cmd_arg;
    logic [127:0] cmd_payload;
    logic         frame_err;
    logic         overrun;
    logic         busy;

    int n_total = 0;
    int n_pass  = 0;
    int err_seen = 0, err_exp = 0;
    int ovr_seen = 0, ovr_exp = 0;
    frame_t     exp_q[$];
    logic [7:0] txq[$];

    uart_cmd_framer #(.TIMEOUT_CYC(16), .TO_W(5)) dut (
        .clk(clk), .nreset(nreset), .rx_data(rx_data), .rx_valid(rx_valid),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
        .cmd_arg(cmd_arg), .cmd_payload(cmd_payload), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams txq back-to-back, one byte per cycle.
    task automatic send_all();
        while (txq.size() > 0) begin
            rx_data  = txq.pop_front();
            rx_valid = 1'b1;
            tick();
        end
        rx_valid = 1'b0;
    endtask

    task automatic push_short(input logic [7:0] a);
        exp_q.push_back('{code: 8'h41, arg: a, pl: {a, 120'd0}});
    endtask

    // Monitor: pulse accounting and scoreboard pop on every accepted frame.
    initial begin
        logic prev_err, prev_ovr;
        frame_t e;
        prev_err = 1'b0;
        prev_ovr = 1'b0;
        forever begin
            @(negedge clk);
            if (nreset) begin
                if (frame_err) err_seen++;
                if (overrun) ovr_seen++;
                if (frame_err && prev_err) begin
                    n_total++;
                    $display("FAIL frame_err_width: got 2+ cycles required 1");
                end
                if (overrun && prev_ovr) begin
                    n_total++;
                    $display("FAIL overrun_width: got 2+ cycles required 1");
                end
                if (cmd_valid && cmd_ready) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_frame: got code %h required none", cmd_code);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_code", {120'd0, cmd_code}, {120'd0, e.code});
                        check("frame_arg", {120'd0, cmd_arg}, {120'd0, e.arg});
                        check("frame_payload", cmd_payload, e.pl);
                    end
                end
            end
            prev_err = frame_err;
            prev_ovr = overrun;
        end
    end

    initial begin
        // Reset state
        tick(); tick();
        check("rst_valid", {127'd0, cmd_valid}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_err", {127'd0, frame_err}, 128'd0);
        check("rst_ovr", {127'd0, overrun}, 128'd0);
        check("rst_code", {120'd0, cmd_code}, 128'd0);
        check("rst_payload", cmd_payload, 128'd0);
        nreset = 1'b1;
        tick();

        // Short frame held until ready
        push_short(8'h43);
        txq = '{8'h41, 8'h43, 8'h41};
        send_all();
        check("t1_valid_latency", {127'd0, cmd_valid}, 128'd1);
        check("t1_busy", {127'd0, busy}, 128'd1);
        tick(); tick(); tick();
        check("t1_held", {127'd0, cmd_valid}, 128'd1);
        check("t1_held_code", {120'd0, cmd_code}, 128'h41);
        check("t1_held_payload", cmd_payload, {8'h43, 120'd0});
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("t1_valid_drop", {127'd0, cmd_valid}, 128'd0);
        check("t1_idle", {127'd0, busy}, 128'd0);

        // Long frame 42
        exp_q.push_back('{code: 8'h42, arg: 8'h00, pl: 128'h000102030405060708090A0B0C0D0E0F});
        txq.push_back(8'h42);
        for (int i = 0; i < 16; i++) txq.push_back(8'(i));
        txq.push_back(8'h42);
        send_all();
        check("t2_valid", {127'd0, cmd_valid}, 128'd1);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("t2_valid_drop", {127'd0, cmd_valid}, 128'd0);

        // Terminator mismatch (a command byte, which must not restart a frame)
        txq.push_back(8'h43);
        for (int i = 0; i < 16; i++) txq.push_back(8'(8'h10 + i));
        txq.push_back(8'h41);
        send_all();
        err_exp++;
        check("t3_err_pulse", {127'd0, frame_err}, 128'd1);
        check("t3_no_valid", {127'd0, cmd_valid}, 128'd0);
        check("t3_not_reparsed", {127'd0, busy}, 128'd0);
        tick();
        check("t3_err_clear", {127'd0, frame_err}, 128'd0);
        push_short(8'h41);
        txq = '{8'h41, 8'h41, 8'h41};
        send_all();
        check("t3_recover", {127'd0, cmd_valid}, 128'd1);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;

        // Overrun while held, then a new command in the handshake cycle
        push_short(8'hAA);
        txq = '{8'h41, 8'hAA, 8'h41};
        send_all();
        txq = '{8'h55};
        send_all();
        ovr_exp++;
        check("t4_overrun", {127'd0, overrun}, 128'd1);
        check("t4_code_stable", {120'd0, cmd_code}, 128'h41);
        check("t4_arg_stable", {120'd0, cmd_arg}, 128'hAA);
        check("t4_still_valid", {127'd0, cmd_valid}, 128'd1);
        tick();
        check("t4_overrun_clear", {127'd0, overrun}, 128'd0);
        cmd_ready = 1'b1;
        txq = '{8'h41};
        send_all();
        cmd_ready = 1'b0;
        check("t4_hs_valid_drop", {127'd0, cmd_valid}, 128'd0);
        check("t4_hs_new_frame", {127'd0, busy}, 128'd1);
        check("t4_hs_no_overrun", {127'd0, overrun}, 128'd0);
        push_short(8'h5A);
        txq = '{8'h5A, 8'h41};
        send_all();
        check("t4_second_valid", {127'd0, cmd_valid}, 128'd1);
        cmd_ready = 1'b1;
        tick();

        // Back-to-back frames with ready held high
        push_short(8'h01);
        push_short(8'h02);
        txq = '{8'h41, 8'h01, 8'h41, 8'h41, 8'h02, 8'h41};
        send_all();
        tick();
        cmd_ready = 1'b0;
        tick();
        check("b2b_drained", 128'(exp_q.size()), 128'd0);

        // Stray bytes, then reset mid-frame
        txq = '{8'h00, 8'h7F, 8'hFF};
        send_all();
        check("t5_stray_busy", {127'd0, busy}, 128'd0);
        txq = '{8'h40, 8'h01, 8'h02, 8'h03, 8'h04};
        send_all();
        check("t5_partial_busy", {127'd0, busy}, 128'd1);
        nreset = 1'b0;
        #2;
        check("t5_rst_busy", {127'd0, busy}, 128'd0);
        check("t5_rst_code", {120'd0, cmd_code}, 128'd0);
        check("t5_rst_payload", cmd_payload, 128'd0);
        tick();
        nreset = 1'b1;
        tick();
        exp_q.push_back('{code: 8'h40, arg: 8'h20, pl: 128'h202122232425262728292A2B2C2D2E2F});
        txq.push_back(8'h40);
        for (int i = 0; i < 16; i++) txq.push_back(8'(8'h20 + i));
        txq.push_back(8'h40);
        send_all();
        check("t5_clean_valid", {127'd0, cmd_valid}, 128'd1);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;

        // Inter-byte timeout
        txq = '{8'h41};
        send_all();
`ifdef CMD_FRAMER_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick();
        check("t6_no_early_err", {127'd0, frame_err}, 128'd0);
        check("t6_busy_before", {127'd0, busy}, 128'd1);
        tick();
        err_exp++;
        check("t6_timeout_err", {127'd0, frame_err}, 128'd1);
        check("t6_idle_after", {127'd0, busy}, 128'd0);
        tick();
`else
        for (int i = 0; i < 20; i++) tick();
        check("t6_still_busy", {127'd0, busy}, 128'd1);
        push_short(8'h07);
        txq = '{8'h07, 8'h41};
        send_all();
        check("t6_late_frame", {127'd0, cmd_valid}, 128'd1);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        tick();
`endif

        check("frame_err_count", 128'(err_seen), 128'(err_exp));
        check("overrun_count", 128'(ovr_seen), 128'(ovr_exp));
        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
